initial_logic: RTL and testbench
================================

# initial_logic

Ingress half of the transaction-layer datapath: accepts 6-bit words from the upstream source, buffers them in a small internal FIFO, and dispatches each word in order to the VC0 or VC1 virtual-channel FIFO selected by its VC bit. It is the writer for the VC FIFOs that final_logic drains. It provides upstream flow control (pause), an overflow error flag, and an idle indication.

## Interface
- DATA_WIDTH, 6, word width; bit 5 = VC select (0→VC0, 1→VC1), bit 4 = destination (D0/D1, passed through untouched), bits 3:0 = payload
- DEPTH, 4, internal FIFO depth; power of two, ≥2
- PAUSE_THRESH, 3, occupancy at or above which pause_in asserts; 1..DEPTH
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- push_in  in  1  upstream write strobe
- data_in  in  DATA_WIDTH  upstream word, sampled when push_in=1
- almost_full_VC0  in  1  VC0 FIFO cannot accept further words
- almost_full_VC1  in  1  VC1 FIFO cannot accept further words
- push_VC0  out  1  write strobe to VC0 FIFO, registered
- push_VC1  out  1  write strobe to VC1 FIFO, registered
- data_in_VC0  out  DATA_WIDTH  word to VC0 FIFO, valid with push_VC0
- data_in_VC1  out  DATA_WIDTH  word to VC1 FIFO, valid with push_VC1
- pause_in  out  1  upstream must stop pushing
- error_in  out  1  one-cycle pulse: a push was dropped
- idle  out  1  FIFO empty and no VC push in flight

## Operation
- Reset (asserted): all outputs 0, read/write pointers 0, count 0, storage cleared; holds while reset=1; takes effect mid-operation without waiting for an edge; in-flight words are discarded.
- Internal FIFO: write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH).
- Write: push_in=1 and count<DEPTH → store data_in at write pointer, advance it.
- Overflow: push_in=1 and count==DEPTH and no pop this cycle → word dropped, error_in=1 for exactly the next cycle, state otherwise unchanged.
- Dispatch: head word H exists (count>0) and almost_full of VC[H[5]] is 0 → pop H; at next edge push_VC{H[5]}=1, data_in_VC{H[5]}=H; other VC strobe 0.
- Strict order: if the head's VC is almost-full, nothing is popped (head-of-line blocking); the other VC is not served out of order.
- At most one pop per cycle; push_VCx is high for one cycle per popped word; data_in_VCx holds its last value when strobe is 0.
- Simultaneous write and pop: both occur, count unchanged; permitted at count==DEPTH (no error, write accepted since a slot frees this cycle).
- No bypass: a word written at edge N is never popped at edge N.
- pause_in = (count ≥ PAUSE_THRESH), registered from post-update count.
- idle = (count==0) and push_VC0==0 and push_VC1==0.
- Bit 4 and payload never modified.

## Timing
- Write-to-dispatch latency: word written at edge N → push_VCx high after edge N+1 at earliest (1 cycle).
- almost_full_VCx sampled in the cycle of the pop decision; assertion blocks the pop at the same edge.
- pause_in and error_in valid one cycle after the causing edge; upstream may overrun by ≤1 word after pause_in rises, so PAUSE_THRESH ≤ DEPTH−1 gives lossless flow.
- Sustained throughput: one word per cycle when target VC not almost-full.
- Release of reset: first write accepted at the first rising edge with reset=0.

## Test plan
- Reset: assert reset mid-stream with 3 words buffered → all outputs 0 immediately, idle=1 after release, no stale pushes.
- Routing: push 6'b0_1_0101 then 6'b1_0_1010 on consecutive cycles → push_VC0 with 6'h15 one cycle after first write, push_VC1 with 6'h2A the following cycle; bits 4:0 unchanged.
- Head-of-line block: almost_full_VC0=1, push VC0 word then VC1 word → no pushes; drop almost_full_VC0 → VC0 word, then VC1 word, in order.
- Pause/overflow: both almost_full=1, push 5 words (DEPTH=4) → pause_in rises after 3rd write, 5th dropped with error_in one-cycle pulse, count stays 4.
- Full + simultaneous: count=4, almost_full_VC1=0, head VC1, push_in=1 → pop and write same cycle, no error, count stays 4.
- Wrap-around: stream 10 words with alternating VC bits, no backpressure → all 10 emitted in order, one per cycle after 1-cycle latency, pointers wrap correctly.

Source files
------------

// File: rtl/initial_logic_if.sv
// ============================================================================
// Module   : initial_logic_if
// Purpose  : Upstream-write and VC-FIFO-write signal bundle for initial_logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface initial_logic_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  push_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  almost_full_VC0;
  logic                  almost_full_VC1;
  logic                  push_VC0;
  logic                  push_VC1;
  logic [DATA_WIDTH-1:0] data_in_VC0;
  logic [DATA_WIDTH-1:0] data_in_VC1;
  logic                  pause_in;
  logic                  error_in;
  logic                  idle;

  // Environment side: upstream source plus the VC FIFOs' full flags.
  modport master (
    output push_in, data_in, almost_full_VC0, almost_full_VC1,
    input  push_VC0, push_VC1, data_in_VC0, data_in_VC1, pause_in, error_in, idle
  );

  // Ingress block side.
  modport slave (
    input  push_in, data_in, almost_full_VC0, almost_full_VC1,
    output push_VC0, push_VC1, data_in_VC0, data_in_VC1, pause_in, error_in, idle
  );
endinterface

`default_nettype wire

// File: rtl/initial_logic.sv
// ============================================================================
// Module   : initial_logic
// Purpose  : Ingress FIFO that dispatches words in order to VC0/VC1 by bit 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module initial_logic #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEPTH        = 4,
  parameter int PAUSE_THRESH = 3
) (
  input  logic            clk,
  input  logic            reset,
  initial_logic_if.slave  bus
);

  localparam int            AW           = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THRESH_COUNT = (AW+1)'(PAUSE_THRESH);
  localparam logic [AW:0]   ONE_COUNT    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR      = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_next;

  logic [DATA_WIDTH-1:0] head;
  logic                  head_vc;
  logic                  head_blocked;
  logic                  pop;
  logic                  wr_en;
  logic                  overflow;

  // Pop decision uses count from before this edge, so a word written now
  // can never be dispatched in the same cycle.
  always_comb begin
    head         = mem[rd_ptr];
    head_vc      = head[DATA_WIDTH-1];
    head_blocked = head_vc ? bus.almost_full_VC1 : bus.almost_full_VC0;
    pop          = (count != '0) && !head_blocked;
    wr_en        = bus.push_in && ((count != FULL_COUNT) || pop);
    overflow     = bus.push_in && !wr_en;
    count_next   = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + ONE_COUNT;
      2'b01:   count_next = count - ONE_COUNT;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      count <= count_next;
    end
  end

  // Idle is registered so every output is low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.push_VC0    <= 1'b0;
      bus.push_VC1    <= 1'b0;
      bus.data_in_VC0 <= '0;
      bus.data_in_VC1 <= '0;
      bus.pause_in    <= 1'b0;
      bus.error_in    <= 1'b0;
      bus.idle        <= 1'b0;
    end else begin
      bus.push_VC0 <= pop && !head_vc;
      bus.push_VC1 <= pop && head_vc;
      if (pop && !head_vc) begin
        bus.data_in_VC0 <= head;
      end
      if (pop && head_vc) begin
        bus.data_in_VC1 <= head;
      end
      bus.pause_in <= (count_next >= THRESH_COUNT);
      bus.error_in <= overflow;
      bus.idle     <= (count_next == '0) && !pop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_initial_logic.sv
// ============================================================================
// Module   : tb_initial_logic
// Purpose  : Self-checking bench for initial_logic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_initial_logic;

  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int PT    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  initial_logic_if #(.DATA_WIDTH(DW)) bus ();

  initial_logic #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .PAUSE_THRESH (PT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a word queue plus the expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last0, last1;
  logic          e_p0, e_p1, e_pause, e_err, e_idle;

  task automatic model_reset();
    q.delete();
    last0   = '0;
    last1   = '0;
    e_p0    = 1'b0;
    e_p1    = 1'b0;
    e_pause = 1'b0;
    e_err   = 1'b0;
    e_idle  = 1'b0;
  endtask

  task automatic step(input logic push, input logic [DW-1:0] d,
                      input logic af0, input logic af1);
    logic [DW-1:0] h;
    logic          pop, acc;
    bus.push_in         = push;
    bus.data_in         = d;
    bus.almost_full_VC0 = af0;
    bus.almost_full_VC1 = af1;
    h   = '0;
    pop = 1'b0;
    if (q.size() > 0) begin
      h   = q[0];
      pop = h[5] ? !af1 : !af0;
    end
    acc   = push && ((q.size() < DEPTH) || pop);
    e_err = push && !acc;
    e_p0  = pop && !h[5];
    e_p1  = pop && h[5];
    if (e_p0) last0 = h;
    if (e_p1) last1 = h;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    e_pause = (q.size() >= PT);
    e_idle  = (q.size() == 0) && !pop;
    @(posedge clk);
    #1;
    cyc++;
    checks += 7;
    if (bus.push_VC0 !== e_p0) begin errors++;
      $display("FAIL push_VC0 cyc=%0d got=%b exp=%b", cyc, bus.push_VC0, e_p0); end
    if (bus.push_VC1 !== e_p1) begin errors++;
      $display("FAIL push_VC1 cyc=%0d got=%b exp=%b", cyc, bus.push_VC1, e_p1); end
    if (bus.data_in_VC0 !== last0) begin errors++;
      $display("FAIL data_VC0 cyc=%0d got=%h exp=%h", cyc, bus.data_in_VC0, last0); end
    if (bus.data_in_VC1 !== last1) begin errors++;
      $display("FAIL data_VC1 cyc=%0d got=%h exp=%h", cyc, bus.data_in_VC1, last1); end
    if (bus.pause_in !== e_pause) begin errors++;
      $display("FAIL pause_in cyc=%0d got=%b exp=%b", cyc, bus.pause_in, e_pause); end
    if (bus.error_in !== e_err) begin errors++;
      $display("FAIL error_in cyc=%0d got=%b exp=%b", cyc, bus.error_in, e_err); end
    if (bus.idle !== e_idle) begin errors++;
      $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, bus.idle, e_idle); end
  endtask

  task automatic test_reset();
    bus.push_in = 1'b0; bus.data_in = '0;
    bus.almost_full_VC0 = 1'b0; bus.almost_full_VC1 = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({bus.push_VC0, bus.push_VC1, bus.pause_in, bus.error_in, bus.idle,
         bus.data_in_VC0, bus.data_in_VC1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b%b %h %h exp=all zero", bus.push_VC0,
               bus.push_VC1, bus.pause_in, bus.error_in, bus.idle,
               bus.data_in_VC0, bus.data_in_VC1);
    end
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (bus.idle !== 1'b1) begin errors++;
      $display("FAIL idle_after_reset got=%b exp=1", bus.idle); end
  endtask

  task automatic test_routing();
    step(1'b1, 6'b0_1_0101, 1'b0, 1'b0);
    step(1'b1, 6'b1_0_1010, 1'b0, 1'b0);
    checks++;
    if (!(bus.push_VC0 === 1'b1 && bus.data_in_VC0 === 6'h15)) begin errors++;
      $display("FAIL route_vc0 got=%b/%h exp=1/15", bus.push_VC0, bus.data_in_VC0); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (!(bus.push_VC1 === 1'b1 && bus.data_in_VC1 === 6'h2A)) begin errors++;
      $display("FAIL route_vc1 got=%b/%h exp=1/2a", bus.push_VC1, bus.data_in_VC1); end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_hol_block();
    step(1'b1, 6'h07, 1'b1, 1'b0);
    step(1'b1, 6'h38, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    // First word targets VC1 so the next scenario finds a VC1 head.
    step(1'b1, 6'h21, 1'b1, 1'b1);
    step(1'b1, 6'h02, 1'b1, 1'b1);
    step(1'b1, 6'h33, 1'b1, 1'b1);
    step(1'b1, 6'h04, 1'b1, 1'b1);
    step(1'b1, 6'h25, 1'b1, 1'b1);
    checks++;
    if (bus.error_in !== 1'b1) begin errors++;
      $display("FAIL overflow_err got=%b exp=1", bus.error_in); end
    step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_full_simultaneous();
    step(1'b1, 6'h16, 1'b1, 1'b0);
    checks++;
    if (!(bus.error_in === 1'b0 && bus.push_VC1 === 1'b1 && bus.pause_in === 1'b1)) begin
      errors++;
      $display("FAIL full_simul got err=%b p1=%b pause=%b exp err=0 p1=1 pause=1",
               bus.error_in, bus.push_VC1, bus.pause_in);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] w;
      w = DW'(i) | ((i % 2) ? 6'h20 : 6'h00) | ((i % 3 == 0) ? 6'h10 : 6'h00);
      step(1'b1, w, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 7), DW'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(6'h11 + i * 17), 1'b1, 1'b1);
    // Reset arrives between edges and must clear outputs without a clock.
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.push_VC0, bus.push_VC1, bus.pause_in, bus.error_in, bus.idle} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b%b%b%b%b exp=00000", bus.push_VC0, bus.push_VC1,
               bus.pause_in, bus.error_in, bus.idle);
    end
    model_reset();
    bus.push_in = 1'b0;
    bus.almost_full_VC0 = 1'b0;
    bus.almost_full_VC1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_routing();
    test_hol_block();
    test_overflow();
    test_full_simultaneous();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
